arm7tdmi_cp15_unit: RTL and testbench

System-control coprocessor (CP15) attached to the core's coprocessor port, downstream of the execute stage. It accepts MRC/MCR/CDP/LDC/STC requests over a valid/ready handshake and returns read data or an undefined-instruction indication. It holds the ID, control, fault-status, fault-address and process-ID registers, and exports the control register to the core.

---
 rtl/arm7tdmi_cp15_unit.sv | 180 ++++++++++++++++++
 tb/tb_arm7tdmi_cp15_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_cp15_unit.sv
// CP15 system-control coprocessor: the c0/c1/c5/c6/c13 registers behind a
// valid/ready coprocessor port with a fixed response latency.
module arm7tdmi_cp15_unit #(
  parameter logic [31:0] ID_VALUE   = 32'h41007700,
  parameter logic [31:0] CTRL_WMASK = 32'h00000087,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cp_valid,
  input  logic [1:0]  cp_op,
  input  logic [3:0]  cp_num,
  input  logic [2:0]  cp_opcode1,
  input  logic [3:0]  cp_crn,
  input  logic [3:0]  cp_crm,
  input  logic [2:0]  cp_opcode2,
  input  logic [31:0] cp_wdata,
  input  logic        cp_abort,
  input  logic        fault_valid,
  input  logic [7:0]  fault_status,
  input  logic [31:0] fault_addr,
  output logic        cp_present,
  output logic        cp_ready,
  output logic        cp_exception,
  output logic [31:0] cp_rdata,
  output logic        cp_busy,
  output logic [31:0] ctrl_reg
);

  localparam logic [1:0] OP_MCR = 2'b01;
  localparam logic [1:0] OP_MRC = 2'b10;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  crn_q, crn_d;
  logic [31:0] wdata_q, wdata_d;
  logic        exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] c1_q, c1_d;
  logic [7:0]  c5_q, c5_d;
  logic [31:0] c6_q, c6_d;
  logic [6:0]  c13_q, c13_d;

  logic [3:0]  rd_crn_s;
  logic [31:0] rd_val_s;
  logic        req_ok_s;
  logic        commit_s;
  logic        unused_fields_s;

  assign unused_fields_s = &{1'b0, cp_crm, cp_opcode2};

  assign req_ok_s = (cp_num == 4'd15) && ((cp_op == OP_MCR) || (cp_op == OP_MRC)) &&
                    (cp_opcode1 == 3'd0) &&
                    ((cp_crn == 4'd0) || (cp_crn == 4'd1) || (cp_crn == 4'd5) ||
                     (cp_crn == 4'd6) || (cp_crn == 4'd13));

  // With LATENCY==1 the read happens on the accept edge, before crn_q is loaded.
  assign rd_crn_s = (state_q == S_IDLE) ? cp_crn : crn_q;

  always_comb begin
    case (rd_crn_s)
      4'd0:    rd_val_s = ID_VALUE;
      4'd1:    rd_val_s = c1_q;
      4'd5:    rd_val_s = {24'd0, c5_q};
      4'd6:    rd_val_s = c6_q;
      4'd13:   rd_val_s = {c13_q, 25'd0};
      default: rd_val_s = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    crn_d   = crn_q;
    wdata_d = wdata_q;
    exc_d   = exc_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cp_valid && !cp_abort) begin
          op_d    = cp_op;
          crn_d   = cp_crn;
          wdata_d = cp_wdata;
          if (req_ok_s) begin
            exc_d = 1'b0;
            cnt_d = LAT_M1;
            if (LAT_M1 == 4'd0) begin
              state_d = S_RESP;
              rdata_d = (cp_op == OP_MRC) ? rd_val_s : rdata_q;
            end else begin
              state_d = S_BUSY;
            end
          end else begin
            exc_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cp_abort) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
          rdata_d = (op_q == OP_MRC) ? rd_val_s : rdata_q;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          state_d = S_BUSY;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // MCR commits on the edge closing RESP; a same-edge fault report overrides c5/c6.
  assign commit_s = (state_q == S_RESP) && !cp_abort && !exc_q && (op_q == OP_MCR);

  assign c1_d  = (commit_s && crn_q == 4'd1)  ? (wdata_q & CTRL_WMASK) : c1_q;
  assign c13_d = (commit_s && crn_q == 4'd13) ? wdata_q[31:25] : c13_q;
  assign c5_d  = fault_valid ? fault_status :
                 ((commit_s && crn_q == 4'd5) ? wdata_q[7:0] : c5_q);
  assign c6_d  = fault_valid ? fault_addr :
                 ((commit_s && crn_q == 4'd6) ? wdata_q : c6_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      crn_q   <= 4'd0;
      wdata_q <= 32'd0;
      exc_q   <= 1'b0;
      rdata_q <= 32'd0;
      c1_q    <= 32'd0;
      c5_q    <= 8'd0;
      c6_q    <= 32'd0;
      c13_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      crn_q   <= crn_d;
      wdata_q <= wdata_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
      c1_q    <= c1_d;
      c5_q    <= c5_d;
      c6_q    <= c6_d;
      c13_q   <= c13_d;
    end
  end

  assign cp_present   = cp_valid && (cp_num == 4'd15);
  assign cp_ready     = (state_q == S_RESP) && !cp_abort;
  assign cp_exception = cp_ready && exc_q;
  assign cp_rdata     = rdata_q;
  assign cp_busy      = (state_q != S_IDLE);
  assign ctrl_reg     = c1_q;

endmodule

// File: tb/tb_arm7tdmi_cp15_unit.sv
// Directed bench for arm7tdmi_cp15_unit: one instance at LATENCY=2, one at LATENCY=4.
module tb_arm7tdmi_cp15_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        va = 1'b0, vb = 1'b0;
  logic [1:0]  cp_op = 2'd0;
  logic [3:0]  cp_num = 4'd0;
  logic [2:0]  cp_opcode1 = 3'd0;
  logic [3:0]  cp_crn = 4'd0;
  logic [3:0]  cp_crm = 4'd1;
  logic [2:0]  cp_opcode2 = 3'd1;
  logic [31:0] cp_wdata = 32'd0;
  logic        cp_abort = 1'b0;
  logic        fault_valid = 1'b0;
  logic [7:0]  fault_status = 8'd0;
  logic [31:0] fault_addr = 32'd0;

  logic        pres_a, rdy_a, exc_a, busy_a;
  logic [31:0] rdata_a, ctrl_a;
  logic        pres_b, rdy_b, exc_b, busy_b;
  logic [31:0] rdata_b, ctrl_b;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [1:0] CDP = 2'b00, MCR = 2'b01, MRC = 2'b10;

  always #5 clk = ~clk;

  arm7tdmi_cp15_unit #(.LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cp_valid(va), .cp_op(cp_op), .cp_num(cp_num),
    .cp_opcode1(cp_opcode1), .cp_crn(cp_crn), .cp_crm(cp_crm), .cp_opcode2(cp_opcode2),
    .cp_wdata(cp_wdata), .cp_abort(cp_abort), .fault_valid(fault_valid),
    .fault_status(fault_status), .fault_addr(fault_addr), .cp_present(pres_a),
    .cp_ready(rdy_a), .cp_exception(exc_a), .cp_rdata(rdata_a), .cp_busy(busy_a),
    .ctrl_reg(ctrl_a));

  arm7tdmi_cp15_unit #(.LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .cp_valid(vb), .cp_op(cp_op), .cp_num(cp_num),
    .cp_opcode1(cp_opcode1), .cp_crn(cp_crn), .cp_crm(cp_crm), .cp_opcode2(cp_opcode2),
    .cp_wdata(cp_wdata), .cp_abort(cp_abort), .fault_valid(fault_valid),
    .fault_status(fault_status), .fault_addr(fault_addr), .cp_present(pres_b),
    .cp_ready(rdy_b), .cp_exception(exc_b), .cp_rdata(rdata_b), .cp_busy(busy_b),
    .ctrl_reg(ctrl_b));

  // Runs one request on instance A (sel=0) or B (sel=1); returns at the negedge of the
  // ready cycle with cyc = cycles after the accept edge (0 on timeout).
  task automatic xfer(input bit sel, input logic [1:0] op, input logic [3:0] num,
                      input logic [3:0] crn, input logic [31:0] wd,
                      output logic [31:0] rd, output logic exc, output int cyc,
                      output logic pres);
    bit done;
    @(negedge clk);
    cp_op = op; cp_num = num; cp_opcode1 = 3'd0; cp_crn = crn; cp_wdata = wd;
    if (sel) vb = 1'b1; else va = 1'b1;
    #1 pres = sel ? pres_b : pres_a;
    cyc = 0; rd = 32'd0; exc = 1'b0; done = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 20 && !done; i++) begin
      @(negedge clk);
      if (sel ? rdy_b : rdy_a) begin
        cyc = i; done = 1'b1;
        rd  = sel ? rdata_b : rdata_a;
        exc = sel ? exc_b : exc_a;
      end
    end
    va = 1'b0; vb = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL xfer_timeout: no cp_ready within 20 cycles (inst %0d op %b crn %0d)", sel, op, crn);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({rdy_a, exc_a, busy_a, rdata_a, ctrl_a} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h expected 0", {rdy_a, exc_a, busy_a, rdata_a, ctrl_a});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rdy_b, exc_b, busy_b, rdata_b, ctrl_b} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_b: got %h expected 0", {rdy_b, exc_b, busy_b, rdata_b, ctrl_b});
    end
  endtask

  task automatic test_id_read();
    logic [31:0] rd; logic exc, pres; int cyc;
    xfer(1'b0, MRC, 4'd15, 4'd0, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({pres, exc, cyc, rd} !== {1'b1, 1'b0, 32'd2, 32'h41007700}) begin
      miscompares++;
      $display("FAIL id_read: got pres=%b exc=%b cyc=%0d rd=%h expected 1 0 2 41007700", pres, exc, cyc, rd);
    end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd; logic exc, pres; int cyc;
    xfer(1'b0, MCR, 4'd15, 4'd1, 32'hFFFFFFFF, rd, exc, cyc, pres);
    vectors++;
    if ({exc, cyc, ctrl_a} !== {1'b0, 32'd2, 32'h0}) begin
      miscompares++;
      $display("FAIL ctrl_wr_resp: got exc=%b cyc=%0d ctrl=%h expected 0 2 00000000", exc, cyc, ctrl_a);
    end
    @(negedge clk);
    vectors++;
    if (ctrl_a !== 32'h00000087) begin
      miscompares++;
      $display("FAIL ctrl_reg_after: got %h expected 00000087", ctrl_a);
    end
    xfer(1'b0, MRC, 4'd15, 4'd1, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if (rd !== 32'h00000087) begin
      miscompares++;
      $display("FAIL ctrl_read_mask: got %h expected 00000087", rd);
    end
    xfer(1'b0, MCR, 4'd15, 4'd1, 32'h00000001, rd, exc, cyc, pres);
    xfer(1'b0, MRC, 4'd15, 4'd1, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({rd, ctrl_a} !== {32'h00000001, 32'h00000001}) begin
      miscompares++;
      $display("FAIL ctrl_read_1: got rd=%h ctrl=%h expected 00000001 00000001", rd, ctrl_a);
    end
  endtask

  task automatic test_unsupported();
    logic [31:0] rd; logic exc, pres; int cyc;
    xfer(1'b0, MRC, 4'd14, 4'd1, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({pres, exc, cyc, rd} !== {1'b0, 1'b1, 32'd1, 32'h00000001}) begin
      miscompares++;
      $display("FAIL unsup_p14: got pres=%b exc=%b cyc=%0d rd=%h expected 0 1 1 00000001", pres, exc, cyc, rd);
    end
    xfer(1'b0, CDP, 4'd10, 4'd0, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({pres, exc, cyc, rd} !== {1'b0, 1'b1, 32'd1, 32'h00000001}) begin
      miscompares++;
      $display("FAIL unsup_cdp: got pres=%b exc=%b cyc=%0d rd=%h expected 0 1 1 00000001", pres, exc, cyc, rd);
    end
    xfer(1'b0, MRC, 4'd15, 4'd2, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({pres, exc, cyc, rd} !== {1'b1, 1'b1, 32'd1, 32'h00000001}) begin
      miscompares++;
      $display("FAIL unsup_crn2: got pres=%b exc=%b cyc=%0d rd=%h expected 1 1 1 00000001", pres, exc, cyc, rd);
    end
    xfer(1'b0, MCR, 4'd15, 4'd0, 32'h12345678, rd, exc, cyc, pres);
    vectors++;
    if ({exc, cyc} !== {1'b0, 32'd2}) begin
      miscompares++;
      $display("FAIL mcr_c0_noop: got exc=%b cyc=%0d expected 0 2", exc, cyc);
    end
    xfer(1'b0, MRC, 4'd15, 4'd0, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if (rd !== 32'h41007700) begin
      miscompares++;
      $display("FAIL c0_after_mcr: got %h expected 41007700", rd);
    end
  endtask

  task automatic test_fault_collision();
    logic [31:0] rd; logic exc, pres; int cyc;
    xfer(1'b0, MCR, 4'd15, 4'd6, 32'h12345678, rd, exc, cyc, pres);
    fault_valid = 1'b1; fault_status = 8'h05; fault_addr = 32'hDEADBEEF;
    @(negedge clk);
    fault_valid = 1'b0;
    xfer(1'b0, MRC, 4'd15, 4'd6, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL fault_far: got %h expected DEADBEEF", rd);
    end
    xfer(1'b0, MRC, 4'd15, 4'd5, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if (rd !== 32'h00000005) begin
      miscompares++;
      $display("FAIL fault_fsr: got %h expected 00000005", rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic exc, pres; int cyc;
    bit seen_rdy;
    @(negedge clk);
    cp_op = MCR; cp_num = 4'd15; cp_crn = 4'd13; cp_wdata = 32'hFE000000; vb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (busy_b !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy: got %b expected 1", busy_b);
    end
    cp_abort = 1'b1; vb = 1'b0;
    @(negedge clk);
    cp_abort = 1'b0;
    seen_rdy = (busy_b !== 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy_b !== 1'b0) seen_rdy = 1'b1;
    end
    vectors++;
    if (seen_rdy) begin
      miscompares++;
      $display("FAIL abort_no_ready: got busy/ready activity expected none");
    end
    xfer(1'b1, MRC, 4'd15, 4'd13, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({cyc, rd} !== {32'd4, 32'h0}) begin
      miscompares++;
      $display("FAIL abort_c13: got cyc=%0d rd=%h expected 4 00000000", cyc, rd);
    end
    xfer(1'b1, MCR, 4'd15, 4'd13, 32'hFFFFFFFF, rd, exc, cyc, pres);
    xfer(1'b1, MRC, 4'd15, 4'd13, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if (rd !== 32'hFE000000) begin
      miscompares++;
      $display("FAIL c13_mask: got %h expected FE000000", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic exc, pres; int cyc;
    @(negedge clk);
    cp_op = MCR; cp_num = 4'd15; cp_crn = 4'd1; cp_wdata = 32'h00000001; va = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; va = 1'b0;
    #1;
    vectors++;
    if ({rdy_a, exc_a, busy_a, rdata_a, ctrl_a} !== 67'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %h expected 0", {rdy_a, exc_a, busy_a, rdata_a, ctrl_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    xfer(1'b0, MRC, 4'd15, 4'd1, 32'd0, rd, exc, cyc, pres);
    vectors++;
    if ({exc, rd} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_c1_read: got exc=%b rd=%h expected 0 00000000", exc, rd);
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_ctrl();
    test_unsupported();
    test_fault_collision();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
